axi_lite_regfile: RTL
=====================

AXI_LITE_REGFILE -- requirements
Module: axi_lite_regfile

Interface
REQ-001 SHALL have parameter C_ADDR_WIDTH, default 9, byte-address width.
REQ-002 SHALL have parameter C_DATA_WIDTH, default 32, data width; legal values are 32 and 64.
REQ-003 SHALL have parameter N_REGS, default 32, register count; N_REGS <= 2**(C_ADDR_WIDTH-ADDR_LSB).
REQ-004 SHALL have parameter RO_MASK, default all-zero, N_REGS bits; bit i=1 makes register i read-only (hardware-fed).
REQ-005 SHALL have ports (name direction width meaning):
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- awaddr/awprot/awvalid/awready, wdata/wstrb/wvalid/wready, bresp/bvalid/bready, araddr/arprot/arvalid/arready, rdata/rresp/rvalid/rready: AXI4-Lite slave, widths C_ADDR_WIDTH, 3, C_DATA_WIDTH, C_DATA_WIDTH/8, 2.
- reg_out  out  N_REGS*C_DATA_WIDTH  current contents of the writable registers; register i occupies slice i.
- status_in  in  N_REGS*C_DATA_WIDTH  read value for registers with RO_MASK[i]=1.
- wr_pulse  out  N_REGS  one-cycle strobe on the cycle register i is committed.
- rd_pulse  out  N_REGS  one-cycle strobe on the cycle register i is sampled for read.

Function
REQ-006 SHALL decode ADDR_LSB=log2(C_DATA_WIDTH/8); index = addr[C_ADDR_WIDTH-1:ADDR_LSB]; low address bits are ignored; awprot/arprot are ignored.
REQ-007 SHALL use a write FSM with states IDLE, HAVE_AW, HAVE_W, RESP.
- IDLE: awready=wready=1. Both handshakes in the same cycle go to RESP; AW only goes to HAVE_AW; W only goes to HAVE_W.
- The channel that already completed holds its ready at 0 until RESP exits.
REQ-008 SHALL commit the write exactly once, on the cycle of entry to RESP.
- Byte lane j is updated only where wstrb[j]=1.
- wr_pulse[index] is asserted in the same cycle.
- bvalid rises on the next cycle, with reg_out already showing the new value.
REQ-009 SHALL hold bvalid and bresp stable until bready; bvalid&&bready returns the FSM to IDLE, with awready/wready high on the following cycle.
REQ-010 SHALL respond bresp=OKAY for a valid writable index, SLVERR (2'b10) for RO_MASK[index]=1 with no commit, and DECERR (2'b11) for index>=N_REGS with no commit and no wr_pulse.
REQ-011 SHALL use a read FSM with states IDLE, DATA.
- IDLE: arready=1.
- An AR handshake at cycle t samples the register (or status_in if RO), pulses rd_pulse[index] at t+1, and asserts rvalid at t+1.
REQ-012 SHALL hold rdata and rresp stable while rvalid&&!rready; rvalid&&rready returns to IDLE.
REQ-013 SHALL return rresp=OKAY for index<N_REGS and DECERR with rdata=0 otherwise.
REQ-014 SHALL, when a read samples the same register on the cycle a write commits, return the pre-commit value.
REQ-015 SHALL run the read and write FSMs independently and concurrently; neither stalls the other.
REQ-016 SHALL drive reg_out slices with RO_MASK[i]=1 as 0.

Reset
REQ-017 SHALL, while rst=1, force all registers to 0, both FSMs to IDLE, and awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata, wr_pulse and rd_pulse to 0.
REQ-018 SHALL raise awready, wready and arready on the first clock edge after rst deasserts.
REQ-019 SHALL abandon any in-flight transaction on reset mid-operation: no partial commit and no response issued.

Structure
REQ-020 SHALL take the response codes (OKAY, SLVERR, DECERR) and the write/read state enums from shared package axi_lite_pkg.
REQ-021 SHALL place the write-channel FSM and capture registers in sub-module axi_lite_wr_fsm; the register array and read path stay in the top level.

Verification
REQ-022 SHALL cover: AW and W in the same cycle, addr 0x008, wdata 0xDEADBEEF, wstrb 0xF -> wr_pulse[2] pulses, bresp OKAY, a subsequent read of 0x008 returns 0xDEADBEEF.
REQ-023 SHALL cover: W three cycles before AW, addr 0x004, wstrb 0x3, data 0x12345678 over a prior value of 0xFFFFFFFF -> reg 1 reads 0xFFFF5678.
REQ-024 SHALL cover: with RO_MASK[3]=1 and status_in slice 3 = 0xA5A5A5A5, a write to 0x00C gets SLVERR and a read of 0x00C returns 0xA5A5A5A5 with OKAY.
REQ-025 SHALL cover: with N_REGS=8, a write and a read to 0x040 each get DECERR, rdata=0, and no pulses.
REQ-026 SHALL cover: bready held low 5 cycles and rready held low 5 cycles -> responses stay stable; a concurrent read/write to the same register returns the old value.
REQ-027 SHALL cover: rst asserted while in HAVE_AW -> all outputs 0, no register change, and a clean transaction after release.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite response codes and register-file FSM state encodings.
package axi_lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_HAVE_AW,
    WR_HAVE_W,
    WR_RESP
  } wr_state_t;

  typedef enum logic {
    RD_IDLE,
    RD_DATA
  } rd_state_t;

endpackage

// File: rtl/axi_lite_wr_fsm.sv
// AXI4-Lite write channel: AW/W capture, commit strobe and B response.
module axi_lite_wr_fsm
  import axi_lite_pkg::*;
#(
  parameter int                C_DATA_WIDTH = 32,
  parameter int                N_REGS       = 32,
  parameter logic [N_REGS-1:0] RO_MASK      = '0,
  parameter int                IDX_W        = 7
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [IDX_W-1:0]          aw_idx,
  input  logic                      awvalid,
  output logic                      awready,
  input  logic [C_DATA_WIDTH-1:0]   wdata,
  input  logic [C_DATA_WIDTH/8-1:0] wstrb,
  input  logic                      wvalid,
  output logic                      wready,
  output logic [1:0]                bresp,
  output logic                      bvalid,
  input  logic                      bready,
  output logic                      commit_en,
  output logic [IDX_W-1:0]          commit_idx,
  output logic [C_DATA_WIDTH-1:0]   commit_data,
  output logic [C_DATA_WIDTH/8-1:0] commit_strb
);

  wr_state_t                 state_q, state_d;
  logic                      init_q;
  logic                      commit_q;
  logic [IDX_W-1:0]          idx_q;
  logic [C_DATA_WIDTH-1:0]   data_q;
  logic [C_DATA_WIDTH/8-1:0] strb_q;
  logic                      aw_hs, w_hs;
  resp_t                     resp;

  function automatic resp_t decode_resp(input logic [IDX_W-1:0] idx);
    logic ro;
    ro = 1'b0;
    for (int unsigned i = 0; i < N_REGS; i++)
      if (idx == IDX_W'(i)) ro = RO_MASK[i];
    if (32'(idx) >= 32'(N_REGS)) return DECERR;
    if (ro) return SLVERR;
    return OKAY;
  endfunction

  assign resp        = decode_resp(idx_q);
  assign aw_hs       = awvalid && awready;
  assign w_hs        = wvalid && wready;
  assign commit_idx  = idx_q;
  assign commit_data = data_q;
  assign commit_strb = strb_q;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= WR_IDLE;
    else     state_q <= state_d;
  end

  // Next-state: collect AW and W in either order, then hold in RESP until B accepted
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WR_IDLE: begin
        if (aw_hs && w_hs) state_d = WR_RESP;
        else if (aw_hs)    state_d = WR_HAVE_AW;
        else if (w_hs)     state_d = WR_HAVE_W;
      end
      WR_HAVE_AW: if (w_hs)              state_d = WR_RESP;
      WR_HAVE_W:  if (aw_hs)             state_d = WR_RESP;
      WR_RESP:    if (bvalid && bready)  state_d = WR_IDLE;
      default:                           state_d = WR_IDLE;
    endcase
  end

  // Outputs: first RESP cycle is the commit cycle, bvalid follows it
  always_comb begin
    awready   = init_q && (state_q == WR_IDLE || state_q == WR_HAVE_W);
    wready    = init_q && (state_q == WR_IDLE || state_q == WR_HAVE_AW);
    bvalid    = (state_q == WR_RESP) && !commit_q;
    bresp     = bvalid ? resp : OKAY;
    commit_en = commit_q && (resp == OKAY);
  end

  // Capture registers and the one-cycle commit flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      init_q   <= 1'b0;
      commit_q <= 1'b0;
      idx_q    <= '0;
      data_q   <= '0;
      strb_q   <= '0;
    end else begin
      init_q   <= 1'b1;
      commit_q <= (state_q != WR_RESP) && (state_d == WR_RESP);
      if (aw_hs) idx_q <= aw_idx;
      if (w_hs) begin
        data_q <= wdata;
        strb_q <= wstrb;
      end
    end
  end

endmodule

// File: rtl/axi_lite_regfile.sv
// AXI4-Lite register file with read-only status slots and access strobes.
module axi_lite_regfile
  import axi_lite_pkg::*;
#(
  parameter int                C_ADDR_WIDTH = 9,
  parameter int                C_DATA_WIDTH = 32,
  parameter int                N_REGS       = 32,
  parameter logic [N_REGS-1:0] RO_MASK      = '0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [C_ADDR_WIDTH-1:0]          awaddr,
  input  logic [2:0]                       awprot,
  input  logic                             awvalid,
  output logic                             awready,
  input  logic [C_DATA_WIDTH-1:0]          wdata,
  input  logic [C_DATA_WIDTH/8-1:0]        wstrb,
  input  logic                             wvalid,
  output logic                             wready,
  output logic [1:0]                       bresp,
  output logic                             bvalid,
  input  logic                             bready,
  input  logic [C_ADDR_WIDTH-1:0]          araddr,
  input  logic [2:0]                       arprot,
  input  logic                             arvalid,
  output logic                             arready,
  output logic [C_DATA_WIDTH-1:0]          rdata,
  output logic [1:0]                       rresp,
  output logic                             rvalid,
  input  logic                             rready,
  output logic [N_REGS*C_DATA_WIDTH-1:0]   reg_out,
  input  logic [N_REGS*C_DATA_WIDTH-1:0]   status_in,
  output logic [N_REGS-1:0]                wr_pulse,
  output logic [N_REGS-1:0]                rd_pulse
);

  localparam int ADDR_LSB = $clog2(C_DATA_WIDTH / 8);
  localparam int IDX_W    = C_ADDR_WIDTH - ADDR_LSB;
  localparam int STRB_W   = C_DATA_WIDTH / 8;

  logic [IDX_W-1:0]        aw_idx, ar_idx, rd_idx_q, commit_idx;
  logic [C_DATA_WIDTH-1:0] commit_data, rd_sel;
  logic [STRB_W-1:0]       commit_strb;
  logic                    commit_en;
  logic [C_DATA_WIDTH-1:0] rd_val [N_REGS];
  rd_state_t               rstate_q, rstate_d;
  logic                    rinit_q, rd_first_q, rd_ok_q, rd_hit, ar_hs;
  logic                    unused_bits;

  assign aw_idx      = awaddr[C_ADDR_WIDTH-1:ADDR_LSB];
  assign ar_idx      = araddr[C_ADDR_WIDTH-1:ADDR_LSB];
  assign unused_bits = ^{awprot, arprot, awaddr[ADDR_LSB-1:0], araddr[ADDR_LSB-1:0]};

  axi_lite_wr_fsm #(
    .C_DATA_WIDTH (C_DATA_WIDTH),
    .N_REGS       (N_REGS),
    .RO_MASK      (RO_MASK),
    .IDX_W        (IDX_W)
  ) u_wr_fsm (
    .clk         (clk),
    .rst         (rst),
    .aw_idx      (aw_idx),
    .awvalid     (awvalid),
    .awready     (awready),
    .wdata       (wdata),
    .wstrb       (wstrb),
    .wvalid      (wvalid),
    .wready      (wready),
    .bresp       (bresp),
    .bvalid      (bvalid),
    .bready      (bready),
    .commit_en   (commit_en),
    .commit_idx  (commit_idx),
    .commit_data (commit_data),
    .commit_strb (commit_strb)
  );

  for (genvar gi = 0; gi < N_REGS; gi++) begin : g_reg
    if (RO_MASK[gi]) begin : g_ro
      assign rd_val[gi] = status_in[gi*C_DATA_WIDTH +: C_DATA_WIDTH];
      assign reg_out[gi*C_DATA_WIDTH +: C_DATA_WIDTH] = '0;
    end else begin : g_rw
      logic [C_DATA_WIDTH-1:0] q;
      logic                    unused_status;
      assign unused_status = ^status_in[gi*C_DATA_WIDTH +: C_DATA_WIDTH];
      assign rd_val[gi] = q;
      assign reg_out[gi*C_DATA_WIDTH +: C_DATA_WIDTH] = q;

      // Byte-lane write of this register on its commit cycle
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          q <= '0;
        end else if (commit_en && commit_idx == IDX_W'(gi)) begin
          for (int unsigned j = 0; j < STRB_W; j++)
            if (commit_strb[j]) q[8*j +: 8] <= commit_data[8*j +: 8];
        end
      end
    end
  end

  // Read mux over register/status values, plus range check
  always_comb begin
    rd_sel = '0;
    for (int unsigned i = 0; i < N_REGS; i++)
      if (ar_idx == IDX_W'(i)) rd_sel = rd_val[i];
    rd_hit = 32'(ar_idx) < 32'(N_REGS);
  end

  // Read state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rstate_q <= RD_IDLE;
    else     rstate_q <= rstate_d;
  end

  // Read next-state
  always_comb begin
    rstate_d = rstate_q;
    unique case (rstate_q)
      RD_IDLE: if (ar_hs)  rstate_d = RD_DATA;
      RD_DATA: if (rready) rstate_d = RD_IDLE;
      default:             rstate_d = RD_IDLE;
    endcase
  end

  // Read handshake outputs and both access strobes
  always_comb begin
    arready  = rinit_q && (rstate_q == RD_IDLE);
    rvalid   = (rstate_q == RD_DATA);
    ar_hs    = arvalid && arready;
    wr_pulse = '0;
    rd_pulse = '0;
    for (int unsigned i = 0; i < N_REGS; i++) begin
      wr_pulse[i] = commit_en && (commit_idx == IDX_W'(i));
      rd_pulse[i] = rd_first_q && rd_ok_q && (rd_idx_q == IDX_W'(i));
    end
  end

  // Read data capture: sampled on the AR handshake edge, so a same-edge commit is not seen
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rinit_q    <= 1'b0;
      rd_first_q <= 1'b0;
      rd_ok_q    <= 1'b0;
      rd_idx_q   <= '0;
      rdata      <= '0;
      rresp      <= OKAY;
    end else begin
      rinit_q    <= 1'b1;
      rd_first_q <= ar_hs;
      if (ar_hs) begin
        rd_idx_q <= ar_idx;
        rd_ok_q  <= rd_hit;
        rdata    <= rd_hit ? rd_sel : '0;
        rresp    <= rd_hit ? OKAY : DECERR;
      end
    end
  end

endmodule
